// File: rtl/booth_controller.sv
// Control FSM for a radix-2 Booth multiplier: captures M then Q from the host,
// then steers the dataPath through DATA_WIDTH add/sub + arithmetic-shift iterations.
module booth_controller #(
    parameter int DATA_WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       eqz,
    input  logic       q0,
    input  logic       qm1,
    output logic       loadA,
    output logic       clearA,
    output logic       shiftA,
    output logic       loadQ,
    output logic       clearQ,
    output logic       shiftQ,
    output logic       loadM,
    output logic       clearM,
    output logic       clearff,
    output logic       addSub,
    output logic       clearCounter,
    output logic       decr,
    output logic       count_en,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] dbg_state_o
);

    localparam int ITER_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(DATA_WIDTH);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOAD_M = 4'd1,
        LOAD_Q = 4'd2,
        INIT   = 4'd3,
        CHECK  = 4'd4,
        ADD    = 4'd5,
        SUB    = 4'd6,
        SHIFT  = 4'd7,
        DONE   = 4'd8
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ITER_W-1:0]   iter_q;
    logic [ITER_W-1:0]   iter_d;
    logic                err_q;
    logic                err_d;

    // Operand handshake: in_ready is high for the whole of LOAD_M/LOAD_Q; an operand
    // is captured on the edge where in_valid && in_ready, and in_valid low simply stalls.

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            iter_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_M;
                    err_d   = 1'b0;
                end
            end
            LOAD_M: begin
                if (in_valid) begin
                    state_d = LOAD_Q;
                end
            end
            LOAD_Q: begin
                if (in_valid) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                iter_d  = '0;
                state_d = CHECK;
            end
            CHECK: begin
                if (eqz) begin
                    state_d = DONE;
                end else if (iter_q == ITER_MAX) begin
                    // The counter never reached zero within DATA_WIDTH shifts.
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    case ({q0, qm1})
                        2'b01:   state_d = ADD;
                        2'b10:   state_d = SUB;
                        default: state_d = SHIFT;
                    endcase
                end
            end
            ADD: begin
                state_d = SHIFT;
            end
            SUB: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                if (iter_q != ITER_MAX) begin
                    iter_d = iter_q + ITER_W'(1);
                end
                state_d = CHECK;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes decode the registered state; only the operand loads also qualify on in_valid.
    always_comb begin
        in_ready     = 1'b0;
        loadA        = 1'b0;
        clearA       = 1'b0;
        shiftA       = 1'b0;
        loadQ        = 1'b0;
        clearQ       = 1'b0;
        shiftQ       = 1'b0;
        loadM        = 1'b0;
        clearM       = 1'b0;
        clearff      = 1'b0;
        addSub       = 1'b0;
        clearCounter = 1'b0;
        decr         = 1'b0;
        count_en     = 1'b0;
        done         = 1'b0;
        case (state_q)
            LOAD_M: begin
                in_ready = 1'b1;
                clearM   = 1'b1;
                loadM    = in_valid;
            end
            LOAD_Q: begin
                in_ready = 1'b1;
                clearQ   = 1'b1;
                loadQ    = in_valid;
            end
            INIT: begin
                clearA       = 1'b1;
                clearff      = 1'b1;
                clearCounter = 1'b1;
                count_en     = 1'b1;
            end
            ADD: begin
                addSub = 1'b1;
                loadA  = 1'b1;
            end
            SUB: begin
                addSub = 1'b0;
                loadA  = 1'b1;
            end
            SHIFT: begin
                shiftA   = 1'b1;
                shiftQ   = 1'b1;
                decr     = 1'b1;
                count_en = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_booth_controller.sv
// Bench for booth_controller: a behavioural dataPath closes the loop, vectors carry
// hand-computed latencies, strobe counts and products.
module tb_booth_controller;

    localparam int DW      = 16;
    localparam int TIMEOUT = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic [DW-1:0] din = '0;
    logic force_eqz_low = 1'b0;

    logic in_ready, eqz, q0, qm1;
    logic loadA, clearA, shiftA, loadQ, clearQ, shiftQ, loadM, clearM;
    logic clearff, addSub, clearCounter, decr, count_en, busy, done, err;
    logic [3:0] dbg_state;
    logic [16:0] outs;

    always #5 clk = ~clk;

    booth_controller #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .eqz(eqz), .q0(q0), .qm1(qm1),
        .loadA(loadA), .clearA(clearA), .shiftA(shiftA), .loadQ(loadQ), .clearQ(clearQ),
        .shiftQ(shiftQ), .loadM(loadM), .clearM(clearM), .clearff(clearff), .addSub(addSub),
        .clearCounter(clearCounter), .decr(decr), .count_en(count_en),
        .busy(busy), .done(done), .err(err), .dbg_state_o(dbg_state)
    );

    assign outs = {in_ready, loadA, clearA, shiftA, loadQ, clearQ, shiftQ, loadM, clearM,
                   clearff, addSub, clearCounter, decr, count_en, busy, done, err};

    // Behavioural dataPath: load beats clear, A:Q shifts arithmetically, counter loads DW.
    logic [DW-1:0] a_r, q_r, m_r;
    logic          ff_r;
    logic [7:0]    cnt_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0; q_r <= '0; m_r <= '0; ff_r <= 1'b0; cnt_r <= '0;
        end else begin
            if (loadM) m_r <= din;
            else if (clearM) m_r <= '0;
            if (loadA) a_r <= addSub ? a_r + m_r : a_r - m_r;
            else if (shiftA) a_r <= {a_r[DW-1], a_r[DW-1:1]};
            else if (clearA) a_r <= '0;
            if (loadQ) q_r <= din;
            else if (shiftQ) q_r <= {a_r[0], q_r[DW-1:1]};
            else if (clearQ) q_r <= '0;
            if (shiftQ) ff_r <= q_r[0];
            else if (clearff) ff_r <= 1'b0;
            if (count_en) begin
                if (clearCounter) cnt_r <= 8'(DW);
                else if (decr) cnt_r <= cnt_r - 8'd1;
            end
        end
    end

    assign eqz = (cnt_r == 8'd0) && !force_eqz_low;
    assign q0  = q_r[0];
    assign qm1 = ff_r;

    typedef struct {
        logic [DW-1:0]   m;
        logic [DW-1:0]   q;
        int              stall_m;
        int              stall_q;
        int              pulse_cyc;
        bit              wd;
        int              exp_done;
        int              exp_shifts;
        int              exp_adds;
        int              exp_subs;
        logic [2*DW-1:0] exp_prod;
        bit              exp_err;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [DW-1:0] m, input logic [DW-1:0] q,
                                input int sm, input int sq, input int pc, input bit wd,
                                input int d, input int sh, input int ad, input int sb,
                                input logic [2*DW-1:0] p, input bit e);
        vec_t v;
        v.m = m; v.q = q; v.stall_m = sm; v.stall_q = sq; v.pulse_cyc = pc; v.wd = wd;
        v.exp_done = d; v.exp_shifts = sh; v.exp_adds = ad; v.exp_subs = sb;
        v.exp_prod = p; v.exp_err = e;
        return v;
    endfunction

    task automatic run_op(input string nm, input vec_t v);
        int cyc, done_cyc, shifts, adds, subs, rdy, ldm, ldq, bad, busy_bad, phase, wait_cnt;
        logic err_c1, err_done;
        logic [2*DW-1:0] prod;
        cyc = 0; done_cyc = -1; shifts = 0; adds = 0; subs = 0; rdy = 0; ldm = 0; ldq = 0;
        bad = 0; busy_bad = 0; phase = 0; wait_cnt = 0; err_c1 = 1'bx; err_done = 1'bx;
        prod = '0;
        force_eqz_low = v.wd;
        @(posedge clk); #2;
        start = 1'b1; din = v.m; in_valid = (v.stall_m == 0);
        while (done_cyc < 0 && cyc <= TIMEOUT) begin
            @(negedge clk);
            if (shiftA) shifts++;
            if (loadA && addSub) adds++;
            if (loadA && !addSub) subs++;
            if (loadA && shiftA) bad++;
            if (decr && !shiftA) bad++;
            if ((loadM || loadQ) && !in_valid) bad++;
            if (in_ready) rdy++;
            if (loadM) ldm++;
            if (loadQ) ldq++;
            if (cyc >= 1 && !busy) busy_bad++;
            if (cyc == 1) err_c1 = err;
            if (done) begin
                done_cyc = cyc; prod = {a_r, q_r}; err_done = err;
            end
            if (in_ready && phase < 2) begin
                if (in_valid) begin phase++; wait_cnt = 0; end
                else wait_cnt++;
            end
            if (done_cyc < 0) begin
                @(posedge clk); #2;
                cyc++;
                start = (cyc == v.pulse_cyc);
                din = (phase == 0) ? v.m : v.q;
                in_valid = (phase < 2) && (wait_cnt >= ((phase == 0) ? v.stall_m : v.stall_q));
            end
        end
        if (done_cyc < 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s.timeout: no done within %0d cycles", nm, TIMEOUT);
        end
        check({nm, ".done_cycle"}, 64'(done_cyc), 64'(v.exp_done));
        check({nm, ".shifts"}, 64'(shifts), 64'(v.exp_shifts));
        check({nm, ".adds"}, 64'(adds), 64'(v.exp_adds));
        check({nm, ".subs"}, 64'(subs), 64'(v.exp_subs));
        check({nm, ".product"}, 64'(prod), 64'(v.exp_prod));
        check({nm, ".err_at_done"}, 64'(err_done), 64'(v.exp_err));
        check({nm, ".err_cleared"}, 64'(err_c1), 64'd0);
        check({nm, ".in_ready_cycles"}, 64'(rdy), 64'(v.stall_m + v.stall_q + 2));
        check({nm, ".loadM_count"}, 64'(ldm), 64'd1);
        check({nm, ".loadQ_count"}, 64'(ldq), 64'd1);
        check({nm, ".strobe_rules"}, 64'(bad), 64'd0);
        check({nm, ".busy_gaps"}, 64'(busy_bad), 64'd0);
        @(posedge clk); #2;
        start = 1'b0; in_valid = 1'b0; force_eqz_low = 1'b0;
        busy_bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (busy || dbg_state != 4'd0 || done) busy_bad++;
        end
        check({nm, ".idle_after"}, 64'(busy_bad), 64'd0);
        check({nm, ".err_sticky"}, 64'(err), 64'(v.exp_err));
    endtask

    vec_t  vecs[7];
    string names[7];

    initial begin
        int seen, dones, busys;
        names[0] = "m3_q0";       vecs[0] = mk(16'h0003, 16'h0000, 0, 0, -1, 0, 37, 16, 0, 0, 32'h0000_0000, 0);
        names[1] = "m5_q1";       vecs[1] = mk(16'h0005, 16'h0001, 0, 0, -1, 0, 39, 16, 1, 1, 32'h0000_0005, 0);
        names[2] = "mneg1_q8000"; vecs[2] = mk(16'hFFFF, 16'h8000, 0, 0, -1, 0, 38, 16, 0, 1, 32'h0000_8000, 0);
        names[3] = "stall_m7_q2"; vecs[3] = mk(16'h0007, 16'h0002, 5, 3, 12, 0, 47, 16, 1, 1, 32'h0000_000E, 0);
        names[4] = "watchdog";    vecs[4] = mk(16'h0003, 16'h0000, 0, 0, 37, 1, 37, 16, 0, 0, 32'h0000_0000, 1);
        names[5] = "after_wd";    vecs[5] = mk(16'hFFFD, 16'h0003, 0, 0, 5, 0, 39, 16, 1, 1, 32'hFFFF_FFF7, 0);
        names[6] = "m2_qneg2";    vecs[6] = mk(16'h0002, 16'hFFFE, 0, 0, -1, 0, 38, 16, 0, 1, 32'hFFFF_FFFC, 0);

        #12;
        check("reset.outputs", 64'(outs), 64'd0);
        check("reset.state", 64'(dbg_state), 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_op(names[i], vecs[i]);

        // Asynchronous reset while the FSM sits in SHIFT.
        @(posedge clk); #2;
        start = 1'b1; in_valid = 1'b1; din = 16'h0003;
        @(posedge clk); #2;
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 50 && seen == 0; i++) begin
            @(negedge clk);
            if (shiftA) seen = 1;
        end
        check("midreset.reached_shift", 64'(seen), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midreset.outputs", 64'(outs), 64'd0);
        check("midreset.state", 64'(dbg_state), 64'd0);
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        dones = 0; busys = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (busy) busys++;
        end
        check("midreset.no_done", 64'(dones), 64'd0);
        check("midreset.stays_idle", 64'(busys), 64'd0);

        run_op("post_reset", vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
